// File: rtl/ifu_prefetch_queue_pkg.sv
// Shared fetch-stage types and constants: PC/instruction widths, reset PC and queue entry layout.
package ifu_prefetch_queue_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Instruction fetch is word aligned; low two target bits are ignored.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_queue_if.sv
// Fetch-stage bundle: PC register link, instruction-memory port, redirect and decode handshake.
interface ifu_prefetch_queue_if;
    import ifu_prefetch_queue_pkg::*;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic            im_en;
    logic [ILEN-1:0] im_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output pc, im_rdata, redirect_valid, redirect_target, out_ready,
        input  next_pc, im_en, out_valid, out_pc, out_instr
    );

    modport slave (
        input  pc, im_rdata, redirect_valid, redirect_target, out_ready,
        output next_pc, im_en, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/ifu_prefetch_queue_fifo.sv
// Synchronous FIFO with flush; head data is read combinationally from storage.
module ifu_prefetch_queue_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Flush drops all entries; storage contents are left as-is since out of range of count.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && !flush) |-> ((count_q < CNT_W'(DEPTH)) || pop));

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Fetch stage around the PC register: issues IM reads at pc, queues {pc, instr} for decode, handles redirects.
module ifu_prefetch_queue
    import ifu_prefetch_queue_pkg::*;
#(
    parameter int unsigned    DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    ifu_prefetch_queue_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic            req_q, req_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count_c;
    logic            credit_c;
    logic            issue_c;
    logic            push_c;
    logic            pop_c;
    logic            flush_c;
    logic [XLEN-1:0] next_pc_c;
    fetch_entry_t    wentry_c;
    fetch_entry_t    head_c;

    // Credit counts queued plus in-flight entries; a same-cycle pop does not return credit.
    always_comb begin
        credit_c  = (SUM_W'(count_c) + SUM_W'(req_q)) < SUM_W'(DEPTH);
        issue_c   = !reset && !bus.redirect_valid && credit_c;
        push_c    = !reset && req_q && !bus.redirect_valid;
        pop_c     = !reset && (count_c != '0) && bus.out_ready && !bus.redirect_valid;
        flush_c   = !reset && bus.redirect_valid;
        wentry_c  = '{pc: req_pc_q, instr: bus.im_rdata};
        next_pc_c = bus.pc;
        if (reset) begin
            next_pc_c = RESET_PC;
        end else if (bus.redirect_valid) begin
            next_pc_c = align_pc(bus.redirect_target);
        end else if (issue_c) begin
            next_pc_c = bus.pc + XLEN'(4);
        end
        req_d    = issue_c;
        req_pc_d = reset ? '0 : bus.pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q    <= 1'b0;
            req_pc_q <= '0;
        end else begin
            req_q    <= req_d;
            req_pc_q <= req_pc_d;
        end
    end

    ifu_prefetch_queue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush_c),
        .push  (push_c),
        .wdata (wentry_c),
        .pop   (pop_c),
        .rdata (head_c),
        .count (count_c)
    );

    assign bus.next_pc   = next_pc_c;
    assign bus.im_en     = issue_c;
    assign bus.out_valid = (count_c != '0);
    assign bus.out_pc    = head_c.pc;
    assign bus.out_instr = head_c.instr;

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Bench for ifu_prefetch_queue: bench-side PC register and IM, queue-based reference model, directed + random stimulus.
module tb_ifu_prefetch_queue;
    import ifu_prefetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifu_prefetch_queue_if bus();

    ifu_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model: queued {pc, instr} pairs plus one outstanding IM read.
    logic [63:0] mq [$];
    logic        m_req    = 1'b0;
    logic [31:0] m_req_pc = '0;
    bit          m_init   = 1'b0;

    logic        s_valid, s_en;
    logic [31:0] s_pc, s_instr, s_next, s_curpc;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // One clock: drive controls, compare against the model, then advance model, PC register and IM.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rt, input logic rdy);
        logic        exp_valid, exp_en, do_pop;
        logic [31:0] exp_next;
        logic [63:0] head;
        @(negedge clk);
        reset               = r;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.out_ready       = rdy;
        #1;
        exp_valid = (mq.size() != 0);
        exp_en    = !r && !rv && ((mq.size() + int'(m_req)) < int'(DEPTH));
        exp_next  = r ? 32'h0000_3000 : rv ? (rt & ~32'h3) : exp_en ? bus.pc + 32'd4 : bus.pc;
        s_valid = bus.out_valid;
        s_en    = bus.im_en;
        s_pc    = bus.out_pc;
        s_instr = bus.out_instr;
        s_next  = bus.next_pc;
        s_curpc = bus.pc;
        chk("next_pc", s_next, exp_next);
        chk("im_en", 32'(s_en), 32'(exp_en));
        if (m_init) begin
            chk("out_valid", 32'(s_valid), 32'(exp_valid));
            if (exp_valid) begin
                head = mq[0];
                chk("out_pc", s_pc, head[63:32]);
                chk("out_instr", s_instr, head[31:0]);
            end
        end
        do_pop = exp_valid && rdy && !rv;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_req    = 1'b0;
            m_req_pc = '0;
            m_init   = 1'b1;
        end else if (rv) begin
            mq.delete();
            m_req = 1'b0;
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (m_req) mq.push_back({m_req_pc, bus.im_rdata});
            m_req    = exp_en;
            m_req_pc = bus.pc;
        end
        bus.im_rdata = exp_en ? imem(bus.pc) : 32'($urandom());
        bus.pc       = s_next;
    endtask

    initial begin
        logic r, rv, rdy;
        logic [31:0] rt;
        reset               = 1'b1;
        bus.pc              = '0;
        bus.im_rdata        = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.out_ready       = 1'b0;

        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_valid", 32'(s_valid), 32'h0);
        chk("rst_out_pc", s_pc, 32'h0);
        chk("rst_out_instr", s_instr, 32'h0);
        chk("rst_next_pc", s_next, 32'h0000_3000);

        // Streaming from reset: two-cycle latency, then one instruction per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            chk("stream_next", s_next, 32'h0000_3004 + 32'(4 * i));
            if (i < 2) begin
                chk("stream_lat", 32'(s_valid), 32'h0);
            end else begin
                chk("stream_valid", 32'(s_valid), 32'h1);
                chk("stream_pc", s_pc, 32'h0000_3000 + 32'(4 * (i - 2)));
                chk("stream_instr", s_instr, (32'h0000_3000 + 32'(4 * (i - 2))) ^ 32'hA5A5_0000);
            end
        end

        // Decode stall: queue fills to DEPTH and fetch holds.
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("stall_count", 32'(mq.size()), 32'(DEPTH));
        chk("stall_im_en", 32'(s_en), 32'h0);
        chk("stall_hold", s_next, s_curpc);
        repeat (12) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one read in flight.
        cycle(1'b0, 1'b1, 32'h0000_3000, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_redir_count", 32'(mq.size()), 32'd3);
        chk("pre_redir_req", 32'(m_req), 32'h1);
        cycle(1'b0, 1'b1, 32'h0000_3101, 1'b0);
        chk("redir_next", s_next, 32'h0000_3100);
        chk("redir_im_en", 32'(s_en), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_flushed", 32'(s_valid), 32'h0);
        chk("redir_pc", s_curpc, 32'h0000_3100);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_refill", 32'(s_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_first_valid", 32'(s_valid), 32'h1);
        chk("redir_first_pc", s_pc, 32'h0000_3100);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect coinciding with a ready decode and a pending push.
        cycle(1'b0, 1'b1, 32'h0000_4000, 1'b1);
        chk("redir_pop_head", 32'(s_valid), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("redir_pop_empty", 32'(s_valid), 32'h0);

        // Reset mid-stream with two queued and one in flight.
        cycle(1'b0, 1'b1, 32'h0000_5000, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("pre_rst_count", 32'(mq.size()), 32'd2);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("midrst_valid", 32'(s_valid), 32'h0);
        chk("midrst_pc", s_curpc, 32'h0000_3000);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("midrst_stale", 32'(s_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        chk("midrst_first", s_pc, 32'h0000_3000);

        // PC wrap-around.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_pc", s_curpc, 32'hFFFF_FFFC);
        chk("wrap_next", s_next, 32'h0000_0000);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap_out_pc", s_pc, 32'hFFFF_FFFC);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(99) == 0);
            rv  = ($urandom_range(19) == 0);
            rt  = 32'($urandom());
            rdy = ($urandom_range(9) < 7);
            cycle(r, rv, rt, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
